fc_neuron_mac: RTL and testbench
================================

Name: fc_neuron_mac

Overview:
- Downstream consumer of the neuron-layer register bank.
- Takes the parallel vector of N_INPUTS 16-bit signed fixed-point activations, plus a locally stored weight vector and bias, and computes one fully-connected neuron output.
- Computes sequentially, one MAC per cycle, under a start/done handshake.
- Weights and bias load through the same address/value/enable style of port used by the layer register bank.

Parameters:
- N_INPUTS, 2, number of activations and weights (at least 1).
- DATA_W, 16, width of activation, weight, bias and result (signed two's complement).
- FRAC_W, 8, fractional bits (Q8.8 by default).
- RELU_EN, 1, 1 = clamp negative results to 0.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low: reset=0 at a rising clk edge resets the block.
- in_values  in  N_INPUTS*DATA_W  activations; element i occupies bits [i*DATA_W +: DATA_W].
- w_load_en  in  1  weight/bias write strobe.
- w_load_address  in  16  addresses 0..N_INPUTS-1 select a weight; N_INPUTS selects the bias; all other addresses are ignored.
- w_load_value  in  DATA_W  write data.
- start  in  1  request one evaluation.
- busy  out  1  evaluation in progress.
- done  out  1  one-cycle pulse; result updated in the same cycle.
- result  out  DATA_W  neuron output, held until the next done.

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE; busy=0, done=0, result=0.
  - All weights, bias, accumulator and index cleared.
  - Reset overrides everything, including mid-evaluation; no done is produced for the aborted evaluation.
- States:
  - IDLE: busy=0.
    - start=1 at an edge: snapshot in_values into an internal vector, set acc = sign-extended bias << FRAC_W, idx=0, go to ACCUM.
    - start=0: stay in IDLE.
  - ACCUM: busy=1.
    - Each edge: acc += snap[idx] * w[idx] (full 2*DATA_W signed product); idx++.
    - After the edge that processes idx=N_INPUTS-1, go to FINISH.
  - FINISH: busy=1.
    - Next edge: r = acc >>> FRAC_W (arithmetic shift, floor).
    - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
    - If RELU_EN and r<0, r=0.
    - result<=r, done<=1, go to IDLE.
- Latency:
  - start sampled at edge E0; ACCUM covers edges E1..EN; FINISH at edge EN+1.
  - done=1 and the new result are visible for exactly one cycle after EN+1.
- Back-to-back: start asserted during the done cycle is accepted, since state is IDLE.
- start while busy=1 is ignored; it is not queued.
- Accumulator width: ACC_W = 2*DATA_W + clog2(N_INPUTS+1) + 1. Overflow is impossible.
- Input snapshot: changes to in_values after the start edge do not affect the running evaluation.
- Weight/bias writes:
  - Accepted only when busy=0; writes while busy are dropped silently.
  - A write and a start on the same edge: the write completes, and the evaluation uses the OLD value of that entry.
  - A written value is used by any start sampled at a later edge.
- done is never asserted while busy=1.

Decomposition:
- Shared package:
  - DATA_W and FRAC_W defaults.
  - State enum {IDLE, ACCUM, FINISH}.
  - Bias-address helper (N_INPUTS).
  - Saturate/ReLU function.
- One natural sub-module: fc_weight_regfile. It holds N_INPUTS+1 entries with synchronous active-low clear, write port gated by ~busy, and a read port indexed by idx plus the bias output.
- The MAC datapath and FSM stay in fc_neuron_mac.

Test Plan:
- Basic dot product:
  - Stimulus: w0=0x0080 (0.5), w1=0xFFC0 (-0.25), bias=0x0040, in_values={x1=0x0200, x0=0x0100}, start pulse.
  - Response: done exactly N_INPUTS+1 cycles after the start edge; result=0x0040; busy high for 3 cycles.
- Saturation:
  - Stimulus: x0=x1=0x7F00, w0=w1=0x7F00, bias=0, RELU_EN=1.
  - Response: result=0x7FFF.
  - With RELU_EN=0 and w1=0x8100, x0=0, x1=0x7F00: result=0x8000.
- ReLU:
  - Stimulus: x0=0x0100, w0=0xFF00 (-1.0), x1=0, bias=0.
  - Response: result=0x0000 with RELU_EN=1; 0xFF00 with RELU_EN=0.
- Hazards:
  - Change in_values and write w0 while busy.
  - Response: result unchanged from the undisturbed run.
  - The next evaluation still uses the old w0, since the write was dropped.
  - A start during busy produces no extra done.
- Reset mid-operation:
  - Stimulus: reset=0 one cycle after start.
  - Response: busy=0, done never pulses, result=0, weights=0.
  - A following start with no loads yields result=0.
- Back-to-back:
  - Stimulus: start held high continuously.
  - Response: done pulses every N_INPUTS+2 cycles with a correct result each time.
  - A write to address N_INPUTS+1 is ignored.

Source files
------------

// File: rtl/fc_neuron_mac_pkg.sv
// fc_neuron_mac_pkg: shared defaults, FSM state type and result-shaping helpers for the neuron MAC.
package fc_neuron_mac_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W_DEF = 8;

    typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

    function automatic int bias_addr(input int n_inputs);
        return n_inputs;
    endfunction

    // Clamp to the signed dw-bit range, then optionally zero negatives.
    function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v, input int dw, input bit relu);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        r = (v > hi) ? hi : (v < lo) ? lo : v;
        return (relu && r < 0) ? 64'sd0 : r;
    endfunction
endpackage

// File: rtl/fc_weight_regfile.sv
// fc_weight_regfile: N_INPUTS weights plus bias, writable only while idle.
// Weights are copied to a shadow set when an evaluation starts, so a same-edge write cannot leak into it.
module fc_weight_regfile
    import fc_neuron_mac_pkg::*;
#(
    parameter int N_INPUTS = 2,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int IDX_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [15:0]       i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_busy,
    input  logic              i_snap,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [DATA_W-1:0] o_bias
);
    logic [DATA_W-1:0] r_w [N_INPUTS+1];
    logic [DATA_W-1:0] r_shadow [N_INPUTS];
    logic              w_we;

    assign w_we = i_we & ~i_busy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i <= N_INPUTS; i++) r_w[i] <= '0;
            for (int i = 0; i < N_INPUTS; i++) r_shadow[i] <= '0;
        end else begin
            for (int i = 0; i <= bias_addr(N_INPUTS); i++)
                if (w_we && i_addr == 16'(i)) r_w[i] <= i_wdata;
            if (i_snap)
                for (int i = 0; i < N_INPUTS; i++) r_shadow[i] <= r_w[i];
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < N_INPUTS; i++)
            if (i_rd_idx == IDX_W'(i)) o_rd_data = r_shadow[i];
    end

    assign o_bias = r_w[N_INPUTS];
endmodule

// File: rtl/fc_neuron_mac.sv
// fc_neuron_mac: sequential fully-connected neuron, one signed MAC per cycle,
// bias-seeded accumulator, floor shift, saturation and optional ReLU.
module fc_neuron_mac
    import fc_neuron_mac_pkg::*;
#(
    parameter int N_INPUTS = 2,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int FRAC_W   = FRAC_W_DEF,
    parameter bit RELU_EN  = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_INPUTS*DATA_W-1:0] in_values,
    input  logic                       w_load_en,
    input  logic [15:0]                w_load_address,
    input  logic [DATA_W-1:0]          w_load_value,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [DATA_W-1:0]          result
);
    localparam int IDX_W = $clog2(N_INPUTS + 1);
    localparam int ACC_W = 2 * DATA_W + $clog2(N_INPUTS + 1) + 1;

    state_t                     r_state;
    state_t                     w_next;
    logic [N_INPUTS*DATA_W-1:0] r_snap;
    logic signed [ACC_W-1:0]    r_acc;
    logic [IDX_W-1:0]           r_idx;
    logic [DATA_W-1:0]          r_result;
    logic                       r_done;
    logic                       w_go;
    logic                       w_last;
    logic [DATA_W-1:0]          w_wt;
    logic signed [DATA_W-1:0]   w_bias;
    logic signed [DATA_W-1:0]   w_x;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_shift;

    fc_weight_regfile #(
        .N_INPUTS(N_INPUTS),
        .DATA_W  (DATA_W),
        .IDX_W   (IDX_W)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .i_we     (w_load_en),
        .i_addr   (w_load_address),
        .i_wdata  (w_load_value),
        .i_busy   (busy),
        .i_snap   (w_go),
        .i_rd_idx (r_idx),
        .o_rd_data(w_wt),
        .o_bias   (w_bias)
    );

    assign w_go    = (r_state == IDLE) && start;
    assign w_last  = r_idx == IDX_W'(N_INPUTS - 1);
    assign w_x     = r_snap[r_idx*DATA_W +: DATA_W];
    assign w_prod  = w_x * $signed(w_wt);
    assign w_shift = r_acc >>> FRAC_W;

    always_ff @(posedge clk) begin
        r_state <= !reset ? IDLE : w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE)  ? (start ? ACCUM : IDLE) :
                 (r_state == ACCUM) ? (w_last ? FINISH : ACCUM) : IDLE;
    end

    always_comb begin
        busy = r_state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_snap   <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= r_state == FINISH;
            if (w_go) begin
                r_snap <= in_values;
                r_acc  <= ACC_W'(w_bias) <<< FRAC_W;
                r_idx  <= '0;
            end else if (r_state == ACCUM) begin
                r_acc <= r_acc + ACC_W'(w_prod);
                r_idx <= r_idx + IDX_W'(1);
            end else if (r_state == FINISH) begin
                r_result <= DATA_W'(sat_relu(64'(w_shift), DATA_W, RELU_EN));
            end
        end
    end

    assign done   = r_done;
    assign result = r_result;
endmodule

// File: tb/tb_fc_neuron_mac.sv
// tb_fc_neuron_mac: scoreboard bench driving a ReLU and a linear instance with identical stimulus.
module tb_fc_neuron_mac;
    localparam int N  = 2;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N*DW-1:0] in_values;
    logic            w_load_en = 1'b0;
    logic [15:0]     w_load_address = '0;
    logic [DW-1:0]   w_load_value = '0;
    logic            start = 1'b0;
    logic            busy1, done1, busy0, done0;
    logic [DW-1:0]   result1, result0;

    logic signed [15:0] m_w [3] = '{default: '0};
    logic signed [15:0] m_x [2] = '{default: '0};
    logic [15:0]        q1 [$];
    logic [15:0]        q0 [$];
    logic [15:0]        e1, e0;
    int                 n_vec = 0;
    int                 n_err = 0;

    always #5 clk = ~clk;

    assign in_values = {m_x[1], m_x[0]};

    fc_neuron_mac #(.N_INPUTS(N), .DATA_W(DW), .FRAC_W(8), .RELU_EN(1'b1)) u_relu (
        .clk(clk), .reset(reset), .in_values(in_values), .w_load_en(w_load_en),
        .w_load_address(w_load_address), .w_load_value(w_load_value), .start(start),
        .busy(busy1), .done(done1), .result(result1)
    );

    fc_neuron_mac #(.N_INPUTS(N), .DATA_W(DW), .FRAC_W(8), .RELU_EN(1'b0)) u_lin (
        .clk(clk), .reset(reset), .in_values(in_values), .w_load_en(w_load_en),
        .w_load_address(w_load_address), .w_load_value(w_load_value), .start(start),
        .busy(busy0), .done(done0), .result(result0)
    );

    function automatic logic [15:0] model(input bit relu);
        longint acc, r;
        acc = longint'(m_w[2]) * 256;
        for (int i = 0; i < N; i++) acc += longint'(m_x[i]) * longint'(m_w[i]);
        r = acc >>> 8;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        return r[15:0];
    endfunction

    always @(negedge clk) begin
        if (done1) begin
            n_vec++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done relu: result=%h with nothing pending", result1);
            end else begin
                e1 = q1.pop_front();
                if (result1 !== e1) begin
                    n_err++;
                    $display("FAIL result relu: got %h expected %h", result1, e1);
                end
            end
            n_vec++;
            if (busy1 !== 1'b0) begin
                n_err++;
                $display("FAIL done_while_busy relu: busy=%b expected 0", busy1);
            end
        end
        if (done0) begin
            n_vec++;
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done linear: result=%h with nothing pending", result0);
            end else begin
                e0 = q0.pop_front();
                if (result0 !== e0) begin
                    n_err++;
                    $display("FAIL result linear: got %h expected %h", result0, e0);
                end
            end
        end
    end

    task automatic push_exp();
        q1.push_back(model(1'b1));
        q0.push_back(model(1'b0));
    endtask

    task automatic load(input logic [15:0] addr, input logic [15:0] val, input bit taken);
        w_load_en = 1'b1;
        w_load_address = addr;
        w_load_value = val;
        @(negedge clk);
        w_load_en = 1'b0;
        if (taken && addr < 16'd3) m_w[addr[1:0]] = val;
    endtask

    // mode 0: plain run; 1: disturb inputs, write and re-start while busy; 2: write w0 on the start edge
    task automatic run_eval(input int mode);
        bit seen;
        int busy_cnt;
        push_exp();
        start = 1'b1;
        if (mode == 2) begin
            w_load_en = 1'b1;
            w_load_address = 16'd0;
            w_load_value = 16'h0200;
            m_w[0] = 16'sh0200;
        end
        seen = 1'b0;
        busy_cnt = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = (mode == 1);
                w_load_en = (mode == 1);
                w_load_address = 16'd0;
                w_load_value = 16'h7000;
                if (mode == 1) begin
                    m_x[0] = 16'sh1111;
                    m_x[1] = 16'sh2222;
                end
            end else if (k == 2) begin
                start = 1'b0;
                w_load_en = 1'b0;
            end
            if (busy1) busy_cnt++;
            if (done1) begin
                seen = 1'b1;
                n_vec++;
                if (k != N + 2) begin
                    n_err++;
                    $display("FAIL latency: done %0d edges after start, expected %0d", k - 1, N + 1);
                end
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: done=0 after 20 cycles, expected a pulse");
        end
        n_vec++;
        if (busy_cnt != N + 1) begin
            n_err++;
            $display("FAIL busy_cycles: got %0d expected %0d", busy_cnt, N + 1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy1, done1, result1, result0} !== 34'd0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b result=%h/%h expected 0", busy1, done1, result1, result0);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        load(16'd0, 16'h0080, 1'b1);
        load(16'd1, 16'hFFC0, 1'b1);
        load(16'd2, 16'h0040, 1'b1);
        m_x[0] = 16'sh0100;
        m_x[1] = 16'sh0200;
        run_eval(0);
    endtask

    task automatic test_saturation();
        load(16'd0, 16'h7F00, 1'b1);
        load(16'd1, 16'h7F00, 1'b1);
        load(16'd2, 16'h0000, 1'b1);
        m_x[0] = 16'sh7F00;
        m_x[1] = 16'sh7F00;
        run_eval(0);
        load(16'd1, 16'h8100, 1'b1);
        m_x[0] = 16'sh0000;
        run_eval(0);
    endtask

    task automatic test_relu();
        load(16'd0, 16'hFF00, 1'b1);
        load(16'd1, 16'h0000, 1'b1);
        m_x[0] = 16'sh0100;
        m_x[1] = 16'sh0000;
        run_eval(0);
    endtask

    task automatic test_hazards();
        bit extra;
        load(16'd0, 16'h0100, 1'b1);
        load(16'd1, 16'h0200, 1'b1);
        load(16'd2, 16'h0010, 1'b1);
        m_x[0] = 16'sh0300;
        m_x[1] = 16'sh0080;
        run_eval(1);
        extra = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done1) extra = 1'b1;
        end
        n_vec++;
        if (extra) begin
            n_err++;
            $display("FAIL ignored_start: extra done=1 seen, expected none");
        end
        m_x[0] = 16'sh0300;
        m_x[1] = 16'sh0080;
        run_eval(0);
        run_eval(2);
        run_eval(0);
    endtask

    task automatic test_reset_mid();
        bit pulsed;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy1, done1, result1, result0} !== 34'd0) begin
            n_err++;
            $display("FAIL reset_abort: busy=%b done=%b result=%h/%h expected 0", busy1, done1, result1, result0);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) m_w[i] = '0;
        pulsed = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done1) pulsed = 1'b1;
        end
        n_vec++;
        if (pulsed) begin
            n_err++;
            $display("FAIL aborted_done: done=1 after reset, expected none");
        end
        m_x[0] = 16'sh0400;
        m_x[1] = 16'sh0500;
        run_eval(0);
    endtask

    task automatic test_back_to_back();
        int cnt, last;
        load(16'd0, 16'h0100, 1'b1);
        load(16'd1, 16'h0100, 1'b1);
        load(16'd2, 16'h0020, 1'b1);
        load(16'd3, 16'h7777, 1'b0);
        m_x[0] = 16'sh0200;
        m_x[1] = 16'sh0300;
        repeat (3) push_exp();
        start = 1'b1;
        cnt = 0;
        last = 0;
        for (int k = 1; k <= 40 && cnt < 3; k++) begin
            @(negedge clk);
            if (done1) begin
                cnt++;
                if (cnt > 1) begin
                    n_vec++;
                    if (k - last != N + 2) begin
                        n_err++;
                        $display("FAIL b2b_period: got %0d cycles expected %0d", k - last, N + 2);
                    end
                end
                last = k;
                if (cnt == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        n_vec++;
        if (cnt != 3) begin
            n_err++;
            $display("FAIL b2b_count: got %0d dones expected 3", cnt);
        end
        repeat (8) @(negedge clk);
        n_vec++;
        if (q1.size() != 0 || q0.size() != 0) begin
            n_err++;
            $display("FAIL pending: %0d/%0d results outstanding, expected 0", q1.size(), q0.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_relu();
        test_hazards();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
